// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
//
// Writer side of the instruction memory. Receives a program image as a byte
// stream from the UART receiver and writes 32-bit words into the instruction
// RAM write port. The RISC-V core is held in reset while the image loads and
// is released once the complete image has been written.
//
// Image format: 4-byte little-endian word count N, then N little-endian words.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse, begins or restarts a load
//   rx_data      byte from the UART receiver
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte this cycle (decoded from state)
//   WE, A, WD    instruction RAM write port (valid together for one cycle)
//   busy         load in progress
//   done         image fully written
//   error        image rejected (word count larger than memory)
//   cpu_rst_n    core reset, released only when the load is done
//   words_loaded number of words written so far
// -----------------------------------------------------------------------------
module uart_prog_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] WD,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_rst_n,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  state_t                  state_r;
  logic [1:0]              byte_cnt_r;
  logic [31:0]             n_r;
  logic [DATA_WIDTH-1:0]   word_r;
  logic                    we_r;
  logic [ADDR_WIDTH-1:0]   a_r;
  logic [DATA_WIDTH-1:0]   wd_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    error_r;
  logic                    cpu_rst_n_r;
  logic [ADDR_WIDTH:0]     words_loaded_r;

  logic                    rx_ready_s;
  logic                    accept_s;
  logic                    last_byte_s;
  logic [31:0]             n_next_s;
  logic [DATA_WIDTH-1:0]   word_next_s;
  logic [31:0]             wl_plus_one_s;

  // Byte handshake: only LEN and DATA take bytes, and never while start is high.
  always_comb begin
    rx_ready_s = 1'b0;
    case (state_r)
      ST_LEN, ST_DATA: begin
        if (start) begin
          rx_ready_s = 1'b0;
        end else begin
          rx_ready_s = 1'b1;
        end
      end
      default: rx_ready_s = 1'b0;
    endcase
  end

  // Datapath helpers. Bytes shift in from the top so that after four
  // accepts the first byte sits in bits [7:0] (little-endian).
  always_comb begin
    accept_s      = rx_valid & rx_ready_s;
    last_byte_s   = (byte_cnt_r == 2'd3);
    n_next_s      = {rx_data, n_r[31:8]};
    word_next_s   = {rx_data, word_r[DATA_WIDTH-1:8]};
    wl_plus_one_s = {{(32-ADDR_WIDTH-1){1'b0}}, words_loaded_r} + 32'd1;
  end

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      byte_cnt_r     <= 2'd0;
      n_r            <= 32'd0;
      word_r         <= {DATA_WIDTH{1'b0}};
      we_r           <= 1'b0;
      a_r            <= {ADDR_WIDTH{1'b0}};
      wd_r           <= {DATA_WIDTH{1'b0}};
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      cpu_rst_n_r    <= 1'b0;
      words_loaded_r <= {(ADDR_WIDTH+1){1'b0}};
    end else if (start) begin
      // Start (or restart) wins over anything in flight.
      state_r        <= ST_LEN;
      byte_cnt_r     <= 2'd0;
      n_r            <= 32'd0;
      word_r         <= {DATA_WIDTH{1'b0}};
      we_r           <= 1'b0;
      busy_r         <= 1'b1;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      cpu_rst_n_r    <= 1'b0;
      words_loaded_r <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          we_r <= 1'b0;
        end

        ST_LEN: begin
          we_r <= 1'b0;
          if (accept_s) begin
            n_r        <= n_next_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (last_byte_s) begin
              if (n_next_s == 32'd0) begin
                state_r     <= ST_DONE;
                busy_r      <= 1'b0;
                done_r      <= 1'b1;
                cpu_rst_n_r <= 1'b1;
              end else if ({1'b0, n_next_s} > MAX_WORDS) begin
                state_r <= ST_ERROR;
                busy_r  <= 1'b0;
                error_r <= 1'b1;
              end else begin
                state_r <= ST_DATA;
              end
            end
          end
        end

        ST_DATA: begin
          we_r <= 1'b0;
          if (accept_s) begin
            word_r     <= word_next_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (last_byte_s) begin
              // WE/A/WD launch together so they are valid in the WRITE cycle.
              state_r <= ST_WRITE;
              we_r    <= 1'b1;
              a_r     <= words_loaded_r[ADDR_WIDTH-1:0];
              wd_r    <= word_next_s;
            end
          end
        end

        ST_WRITE: begin
          we_r           <= 1'b0;
          words_loaded_r <= words_loaded_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
          if (wl_plus_one_s == n_r) begin
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            cpu_rst_n_r <= 1'b1;
          end else begin
            state_r <= ST_DATA;
          end
        end

        ST_DONE: begin
          we_r <= 1'b0;
        end

        ST_ERROR: begin
          we_r <= 1'b0;
        end

        default: begin
          state_r     <= ST_IDLE;
          we_r        <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          error_r     <= 1'b0;
          cpu_rst_n_r <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready     = rx_ready_s;
  assign WE           = we_r;
  assign A            = a_r;
  assign WD           = wd_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign cpu_rst_n    = cpu_rst_n_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream from the UART receiver and writes 32-bit words into the instruction RAM write port.
- The core fetches from that RAM's read port.
- Holds the RISC-V core in reset while loading. Releases it once the full image is written.
- Image format: 4-byte little-endian word count N, then N words, each little-endian.

Parameters:
- DATA_WIDTH, 32, memory word width; fixed at 32 (4 bytes per word).
- ADDR_WIDTH, 10, memory word-address width; capacity 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins or restarts a load.
- rx_data  input  8  byte from the UART receiver.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- WE  output  1  memory write enable.
- A  output  ADDR_WIDTH  memory word address.
- WD  output  DATA_WIDTH  memory write data.
- busy  output  1  load in progress.
- done  output  1  image fully written.
- error  output  1  image rejected (N too large).
- cpu_rst_n  output  1  core reset, active-low; 0 except in DONE.
- words_loaded  output  ADDR_WIDTH+1  count of words written so far.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE.
  - rx_ready=0, WE=0, A=0, WD=0, busy=0, done=0, error=0, cpu_rst_n=0, words_loaded=0.
  - Byte counter and N cleared.
- All outputs are registered except rx_ready, which is decoded from the state register.
- Byte acceptance: a byte is taken only on a cycle where rx_valid=1 and rx_ready=1. rx_valid with rx_ready=0 is ignored; no byte is lost-tracked.
- States:
  - IDLE: rx_ready=0. start -> LEN. Clear byte counter, N, words_loaded, done, error.
  - LEN: rx_ready=1, busy=1.
    - Accepted bytes fill N[7:0], then N[15:8], N[23:16], N[31:24].
    - After the 4th byte, next state depends on N:
      - N=0 -> DONE.
      - N>2**ADDR_WIDTH -> ERROR.
      - Otherwise -> DATA.
  - DATA: rx_ready=1, busy=1.
    - Accepted bytes are assembled little-endian: first byte -> bits [7:0].
    - After the 4th byte -> WRITE.
  - WRITE: one cycle, rx_ready=0.
    - WE=1, A=words_loaded[ADDR_WIDTH-1:0], WD=assembled word.
    - WE, A and WD are valid together in this cycle only; WE=0 in all other states.
    - words_loaded increments on exit.
    - If words_loaded+1==N -> DONE, else -> DATA.
  - DONE: busy=0, done=1, cpu_rst_n=1, rx_ready=0. Holds until start or reset.
  - ERROR: busy=0, error=1, cpu_rst_n=0, rx_ready=0. Holds until start or reset.
- Latency: WE asserts the cycle after the 4th byte of a word is accepted.
- Maximum rate: one word per 5 cycles (4 accept cycles + 1 WRITE).
- start in any state, including mid-load:
  - Next state LEN; all counters, N, done and error cleared; cpu_rst_n=0.
  - A byte presented in the same cycle is not accepted: rx_ready is forced 0 when start=1.
- N=2**ADDR_WIDTH is legal; the last word is written to address 2**ADDR_WIDTH-1.
- A never wraps.
- Bytes arriving after DONE/ERROR are not accepted (rx_ready=0).
- Reset mid-load: immediate return to IDLE. Partial memory contents are left as written.

Test Plan:
- Nominal load:
  - Stimulus: start, then bytes 02 00 00 00 | 13 05 A0 00 | 6F 00 00 00.
  - Required: WE pulses at A=0 with WD=0x00A00513 and at A=1 with WD=0x0000006F.
  - Then done=1, cpu_rst_n=1, words_loaded=2.
- Gapped stream: same image with rx_valid deasserted for 1-7 random cycles between bytes -> identical writes. No WE during gaps.
- Empty image: start, bytes 00 00 00 00 -> no WE; done=1 the cycle after the 4th byte.
- Oversize image:
  - Stimulus: ADDR_WIDTH=10, N=0x401 (bytes 01 04 00 00).
  - Required: error=1, cpu_rst_n=0, rx_ready=0, no WE.
  - A subsequent start plus a valid image loads normally.
- Restart: start pulse after 2 data bytes of word 0, concurrent with rx_valid=1.
  - Required: that byte is not accepted; the loader re-enters LEN and a fresh 1-word image writes A=0 correctly.
- Reset mid-WRITE: rst_n low during the WE cycle -> all outputs at reset values immediately; cpu_rst_n=0; state IDLE.
